// File: rtl/opb_master_initiator.sv
// opb_master_initiator: single-beat OPB bus master driven by fabric commands.
// One command in flight; handles grant, xferAck/errAck, retry and timeout.
module opb_master_initiator #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32,
    parameter int C_MAX_RETRY  = 8,
    parameter int C_WDOG       = 16
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst_n,
    output logic                          M_request,
    output logic                          M_busLock,
    output logic                          M_select,
    output logic                          M_RNW,
    output logic [0:C_OPB_DWIDTH/8-1]     M_BE,
    output logic                          M_seqAddr,
    output logic [0:C_OPB_AWIDTH-1]       M_ABus,
    output logic [0:C_OPB_DWIDTH-1]       M_DBus,
    input  logic                          OPB_MGrant,
    input  logic                          OPB_xferAck,
    input  logic                          OPB_errAck,
    input  logic                          OPB_retry,
    input  logic                          OPB_timeout,
    input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rnw,
    input  logic [0:C_OPB_AWIDTH-1]       cmd_addr,
    input  logic [0:C_OPB_DWIDTH/8-1]     cmd_be,
    input  logic [0:C_OPB_DWIDTH-1]       cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [0:C_OPB_DWIDTH-1]       rsp_rdata,
    output logic [1:0]                    rsp_status
);
    localparam int BW = C_OPB_DWIDTH / 8;
    localparam int WW = $clog2(C_WDOG + 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_RFAIL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_XFER, S_BACKOFF, S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic                    rnw_q, rnw_d;
    logic [0:C_OPB_AWIDTH-1] addr_q, addr_d;
    logic [0:BW-1]           be_q, be_d;
    logic [0:C_OPB_DWIDTH-1] wdata_q, wdata_d;
    logic [7:0]              retry_q, retry_d;
    logic [WW-1:0]           wdog_q, wdog_d;
    logic                    request_q, request_d;
    logic                    select_q, select_d;
    logic                    m_rnw_q, m_rnw_d;
    logic [0:BW-1]           m_be_q, m_be_d;
    logic [0:C_OPB_AWIDTH-1] abus_q, abus_d;
    logic [0:C_OPB_DWIDTH-1] dbus_q, dbus_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [0:C_OPB_DWIDTH-1] rdata_q, rdata_d;
    logic [1:0]              status_q, status_d;
    logic [8:0]              retry_inc;

    assign retry_inc = {1'b0, retry_q} + 9'd1;

    always_comb begin
        state_d  = state_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        retry_d  = retry_q;
        wdog_d   = wdog_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rnw_d   = cmd_rnw;
                    addr_d  = cmd_addr;
                    be_d    = cmd_be;
                    wdata_d = cmd_wdata;
                    retry_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (OPB_MGrant) begin
                    wdog_d  = WW'(1);
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                wdog_d = wdog_q + WW'(1);
                if (OPB_xferAck) begin
                    status_d = OPB_errAck ? ST_ERR : ST_OK;
                    rdata_d  = (rnw_q && !OPB_errAck) ? OPB_DBus : '0;
                    state_d  = S_RESP;
                end else if (OPB_retry) begin
                    retry_d = retry_inc[7:0];
                    if (retry_inc > 9'(C_MAX_RETRY)) begin
                        status_d = ST_RFAIL;
                        rdata_d  = '0;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_BACKOFF;
                    end
                end else if (OPB_timeout || wdog_q == WW'(C_WDOG)) begin
                    status_d = ST_TMO;
                    rdata_d  = '0;
                    state_d  = S_RESP;
                end
            end
            S_BACKOFF: state_d = S_REQ;
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered copies of what the next state needs
        request_d   = (state_d == S_REQ);
        select_d    = (state_d == S_XFER);
        m_rnw_d     = select_d & rnw_q;
        m_be_d      = select_d ? be_q : '0;
        abus_d      = select_d ? addr_q : '0;
        dbus_d      = (select_d && !rnw_q) ? wdata_q : '0;
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        if (state_d != S_RESP) begin
            rdata_d  = '0;
            status_d = ST_OK;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q     <= S_IDLE;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            retry_q     <= '0;
            wdog_q      <= '0;
            request_q   <= 1'b0;
            select_q    <= 1'b0;
            m_rnw_q     <= 1'b0;
            m_be_q      <= '0;
            abus_q      <= '0;
            dbus_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            status_q    <= ST_OK;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            retry_q     <= retry_d;
            wdog_q      <= wdog_d;
            request_q   <= request_d;
            select_q    <= select_d;
            m_rnw_q     <= m_rnw_d;
            m_be_q      <= m_be_d;
            abus_q      <= abus_d;
            dbus_q      <= dbus_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
        end
    end

    assign M_request  = request_q;
    assign M_busLock  = 1'b0;
    assign M_select   = select_q;
    assign M_RNW      = m_rnw_q;
    assign M_BE       = m_be_q;
    assign M_seqAddr  = 1'b0;
    assign M_ABus     = abus_q;
    assign M_DBus     = dbus_q;
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

endmodule

// File: tb/tb_opb_master_initiator.sv
// Bench for opb_master_initiator: arbiter/slave responder plus transaction-level
// reference model of status, read data, select-cycle count and latency.
module tb_opb_master_initiator;
    localparam int MAXR = 2;
    localparam int WDOG = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        M_request, M_busLock, M_select, M_RNW, M_seqAddr;
    logic [0:3]  M_BE;
    logic [0:31] M_ABus, M_DBus;
    logic        OPB_MGrant = 0, OPB_xferAck = 0, OPB_errAck = 0;
    logic        OPB_retry = 0, OPB_timeout = 0;
    logic [0:31] OPB_DBus = '0;
    logic        cmd_valid = 0, cmd_rnw = 0;
    logic        cmd_ready;
    logic [0:31] cmd_addr = '0, cmd_wdata = '0;
    logic [0:3]  cmd_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [0:31] rsp_rdata;
    logic [1:0]  rsp_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opb_master_initiator #(
        .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
        .C_MAX_RETRY(MAXR), .C_WDOG(WDOG)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n),
        .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select),
        .M_RNW(M_RNW), .M_BE(M_BE), .M_seqAddr(M_seqAddr),
        .M_ABus(M_ABus), .M_DBus(M_DBus),
        .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck),
        .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry),
        .OPB_timeout(OPB_timeout), .OPB_DBus(OPB_DBus),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_status(rsp_status)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_bus_inputs();
        OPB_MGrant  = 0;
        OPB_xferAck = 0;
        OPB_errAck  = 0;
        OPB_retry   = 0;
        OPB_timeout = 0;
        OPB_DBus    = $urandom;
    endtask

    // mode: 0 ack, 1 ack+errAck, 2 ack+retry, 3 silent (watchdog), 4 arbiter timeout at tmo
    // retry phases: slave retries at select index d in the first nret phases
    task automatic txn(input string tag, input bit rnw, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] rdat, input int g, input int nret,
                       input int d, input int mode, input int tmo, input int rdly);
        int phases, exp_sel, elat, last_len;
        logic [1:0]  est;
        logic [31:0] erd;
        int sel_cnt = 0, phase = -1, idx = 0, req_cnt = 0;
        int lat = -1, hold = 0;
        bit prev_sel = 0, acked = 0, done = 0;

        if (nret > MAXR) begin
            phases  = MAXR + 1;
            exp_sel = phases * (d + 1);
            est     = 2'b11;
            erd     = '0;
        end else begin
            phases   = nret + 1;
            last_len = (mode < 3) ? d + 1 : (mode == 3) ? WDOG : tmo + 1;
            exp_sel  = nret * (d + 1) + last_len;
            est      = (mode == 1) ? 2'b01 : (mode >= 3) ? 2'b10 : 2'b00;
            erd      = (rnw && (mode == 0 || mode == 2)) ? rdat : '0;
        end
        elat = 1 + phases * (g + 1) + exp_sel + (phases - 1);

        chk({tag, ".ready_start"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_wdata = wdata;
        for (int cyc = 1; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            cmd_valid = 0;
            cmd_addr  = $urandom;
            clear_bus_inputs();
            if (acked) begin
                rsp_ready = 0;
                chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
                chk({tag, ".ready_back"}, 32'(cmd_ready), 32'd1);
                done = 1;
            end else begin
                chk({tag, ".busy"}, 32'(cmd_ready), 32'd0);
                if (M_select) begin
                    if (!prev_sel) begin
                        phase++;
                        idx = 0;
                    end else begin
                        idx++;
                    end
                    sel_cnt++;
                    req_cnt = 0;
                    chk({tag, ".abus"}, M_ABus, addr);
                    chk({tag, ".be"}, 32'(M_BE), 32'(be));
                    chk({tag, ".rnw"}, 32'(M_RNW), 32'(rnw));
                    chk({tag, ".dbus"}, M_DBus, rnw ? 32'd0 : wdata);
                    if (phase < nret) begin
                        if (idx == d) OPB_retry = 1;
                    end else begin
                        case (mode)
                            0: if (idx == d) OPB_xferAck = 1;
                            1: if (idx == d) begin
                                OPB_xferAck = 1;
                                OPB_errAck  = 1;
                            end
                            2: if (idx == d) begin
                                OPB_xferAck = 1;
                                OPB_retry   = 1;
                            end
                            4: if (idx == tmo) OPB_timeout = 1;
                            default: ;
                        endcase
                    end
                    if (OPB_xferAck && rnw) OPB_DBus = rdat;
                end else begin
                    chk({tag, ".abus_idle"}, M_ABus, 32'd0);
                    chk({tag, ".dbus_idle"}, M_DBus, 32'd0);
                    chk({tag, ".be_idle"}, 32'(M_BE), 32'd0);
                    OPB_xferAck = 1'($urandom);
                    OPB_retry   = 1'($urandom);
                    if (M_request) begin
                        if (req_cnt == g) OPB_MGrant = 1;
                        req_cnt++;
                    end else begin
                        OPB_MGrant = 1'($urandom);
                    end
                end
                if (rsp_valid) begin
                    if (lat < 0) begin
                        lat = cyc;
                        chk({tag, ".latency"}, 32'(lat), 32'(elat));
                        chk({tag, ".sel_cycles"}, 32'(sel_cnt), 32'(exp_sel));
                        chk({tag, ".phases"}, 32'(phase + 1), 32'(phases));
                    end
                    chk({tag, ".status"}, 32'(rsp_status), 32'(est));
                    chk({tag, ".rdata"}, rsp_rdata, erd);
                    if (hold == rdly) begin
                        rsp_ready = 1;
                        acked     = 1;
                    end else begin
                        hold++;
                    end
                end
                prev_sel = M_select;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s.no_response observed=none expected=rsp", tag);
        end
        clear_bus_inputs();
    endtask

    initial begin
        clear_bus_inputs();
        repeat (2) @(negedge clk);
        chk("rst.request", 32'(M_request), 32'd0);
        chk("rst.select", 32'(M_select), 32'd0);
        chk("rst.abus", M_ABus, 32'd0);
        chk("rst.dbus", M_DBus, 32'd0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.lock_seq", {30'd0, M_busLock, M_seqAddr}, 32'd0);
        rst_n = 1;
        @(negedge clk);
        chk("rel.cmd_ready", 32'(cmd_ready), 32'd1);

        txn("rd_min", 1, 32'h010B0200, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        txn("wr_be3", 0, 32'h00000040, 4'b0011, 32'h12345678, 32'h0, 1, 0, 2, 0, 0, 0);
        txn("rd_wr_ack", 0, 32'h00000044, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0, 3, 0, 0, 1);
        txn("retry_fail", 1, 32'h00000100, 4'hF, 32'h0, 32'h11112222, 0, 9, 0, 0, 0, 0);
        txn("retry_ok", 1, 32'h00000104, 4'hF, 32'h0, 32'h33334444, 2, 2, 1, 0, 0, 0);
        txn("wdog", 1, 32'h00000200, 4'hF, 32'h0, 32'h55556666, 0, 0, 0, 3, 0, 0);
        txn("errack", 1, 32'h00000204, 4'hF, 32'h0, 32'h77778888, 0, 0, 1, 1, 0, 0);
        txn("ack_retry", 1, 32'h00000208, 4'hF, 32'h0, 32'h9999AAAA, 0, 0, 0, 2, 0, 0);
        txn("arb_tmo", 0, 32'h0000020C, 4'hC, 32'hBBBBCCCC, 32'h0, 1, 0, 0, 4, 5, 0);
        txn("rsp_hold", 1, 32'h00000300, 4'hF, 32'h0, 32'hDDDDEEEE, 0, 0, 0, 0, 0, 10);

        for (int n = 0; n < 40; n++) begin
            txn("rand", 1'($urandom), $urandom, 4'($urandom_range(1, 15)),
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 10), $urandom_range(0, 3));
        end

        // Reset during a select phase abandons the transaction
        cmd_valid = 1;
        cmd_rnw   = 1;
        cmd_addr  = 32'h0000ABC0;
        cmd_be    = 4'hF;
        @(negedge clk);
        cmd_valid  = 0;
        OPB_MGrant = 1;
        for (int i = 0; i < 20 && !M_select; i++) @(negedge clk);
        OPB_MGrant = 0;
        chk("mid.select_seen", 32'(M_select), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid.select", 32'(M_select), 32'd0);
        chk("mid.request", 32'(M_request), 32'd0);
        chk("mid.abus", M_ABus, 32'd0);
        chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid.cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post.rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post.cmd_ready", 32'(cmd_ready), 32'd1);
            chk("post.select", 32'(M_select), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
